block_sync_ctrl: RTL
====================

# block_sync_ctrl

Lock controller for the 64b/66b sync-header alignment datapath. It sequences the binary seeker array:

- resets the array;
- accepts the array's first reported offset;
- verifies that offset against a run of good sync headers;
- freezes it as the locked slice position;
- monitors header errors, forcing a re-search on loss of lock.

It sits between the seeker array and the downstream block slicer/descrambler, and is the only source of the offset the slicer uses.

## Interface
Parameters:
- LOCK_CNT, 32: consecutive good headers required in VERIFY before lock (1..255).
- ERR_WINDOW, 64: header window length in LOCKED (2..255).
- ERR_LIMIT, 16: bad headers within one window that drop lock (1..ERR_WINDOW).
- SEARCH_TIMEOUT, 4096: dv cycles allowed in SEARCH before re-resetting seekers (1..65535).
- OFFSET_MAX, 65: highest legal offset; larger seeker offsets are rejected.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- buffer_dv  in  1  gearbox buffer holds a new 66-bit block this cycle
- seek_synced_i  in  1  seeker array reports a sync candidate
- seek_offset_i  in  7  seeker array candidate offset
- hdr_i  in  2  sync header at offset_o for the current buffer_dv, extracted combinationally by the slicer
- seek_rst_o  out  1  synchronous reset to the seeker array
- offset_o  out  7  frozen slice offset
- locked_o  out  1  alignment locked
- block_dv_o  out  1  buffer_dv & locked_o, qualified block strobe
- relock_cnt_o  out  8  saturating count of lock losses
- state_o  out  2  current FSM state encoding

## Operation
- **Header validity:** hdr_i is good iff it equals 2'b01 or 2'b10; 2'b00 and 2'b11 are bad. hdr_i is sampled only when buffer_dv=1.
- **States:** RST_SEEK=0, SEARCH=1, VERIFY=2, LOCKED=3.
- **RST_SEEK:**
  - seek_rst_o=1 for exactly 2 clocks, independent of buffer_dv; then go to SEARCH.
  - Clears the search timer, good counter, window counter and bad counter.
- **SEARCH:**
  - On buffer_dv with seek_synced_i=1 and seek_offset_i<=OFFSET_MAX: latch offset_o<=seek_offset_i and go to VERIFY.
  - Otherwise the timer increments on each buffer_dv. On reaching SEARCH_TIMEOUT, go to RST_SEEK.
  - An out-of-range offset is ignored: no latch, and the timer still increments.
- **VERIFY:**
  - offset_o is frozen. Each buffer_dv with a good header increments the good counter.
  - When the counter reaches LOCK_CNT, go to LOCKED.
  - Any bad header sends the FSM to RST_SEEK.
- **LOCKED:**
  - locked_o=1. Each buffer_dv increments the window counter; a bad header also increments the bad counter.
  - If the bad count, including the current header, reaches ERR_LIMIT: go to RST_SEEK and increment relock_cnt_o (saturates at 255).
  - Else if the window counter reaches ERR_WINDOW: clear both counters and stay locked.
- **offset_o:** changes only on the SEARCH→VERIFY transition. It holds its value through RST_SEEK and SEARCH; the slicer ignores it while locked_o=0.
- **Seeker interaction:** seek_synced_i and seek_offset_i are ignored outside SEARCH.

## Timing
- All outputs are registered except block_dv_o, which is combinational: buffer_dv & locked_o.
- **Reset values:**
  - seek_rst_o=1, offset_o=0, locked_o=0, relock_cnt_o=0, state_o=0 (RST_SEEK).
  - After rst_i deasserts, seek_rst_o stays 1 for 2 more clocks, then the FSM enters SEARCH.
- **Lock latency:** locked_o rises on the clock edge that samples the LOCK_CNT-th good header. block_dv_o is first high on the next buffer_dv.
- **Unlock latency:** locked_o falls on the edge that samples the ERR_LIMIT-th bad header. seek_rst_o rises on the same edge.
- **Simultaneous events:** the bad header and the window end are sampled together. The limit check uses the updated bad count before any clearing; unlock has priority over the window clear.
- **Reset mid-operation:** rst_i asserted in any state immediately forces reset values. relock_cnt_o also clears.
- The FSM never skips states. It cannot reach LOCKED from SEARCH without a full VERIFY run.

## Structure
- **Package `aurora_sync_pkg`:**
  - sync_state_t enum (RST_SEEK, SEARCH, VERIFY, LOCKED; 2-bit);
  - HDR_DATA=2'b01, HDR_CTRL=2'b10;
  - OFFSET_W=7;
  - function hdr_good().
- **Sub-module `hdr_err_window`:**
  - Holds the LOCKED window counter, bad counter and limit comparator.
  - Inputs: clk_i, rst_i, clr, dv, bad.
  - Output: limit_hit (combinational on the current sample).
  - Its parameters are the block's ERR_WINDOW and ERR_LIMIT.
- The top level holds the FSM, search timer, good counter, offset register and relock counter.

## Test plan
- **Reset release:** rst_i pulse → seek_rst_o high 2 clocks after release; state_o goes 0→1; all other outputs at reset values.
- **Clean lock:** seek_synced_i=1 with offset 37 on a dv; then 32 good headers (alternating 01/10) → offset_o=37; locked_o rises on the 32nd header; block_dv_o follows buffer_dv.
- **VERIFY failure:** offset 12 latched; 10 good headers, then hdr_i=2'b11 → RST_SEEK; seek_rst_o high 2 clocks; locked_o never asserted; relock_cnt_o stays 0.
- **Error window:**
  - Locked, 15 bad headers spread across one 64-header window → lock is held and counters clear at window end.
  - Next window: 16 bad headers → locked_o falls on the 16th; relock_cnt_o=1.
- **Simultaneous events:** ERR_LIMIT-th bad header on the 64th header of a window → unlock taken, not window clear. Separately, a seeker offset of 70 in SEARCH is ignored.
- **Timeout and saturation:**
  - SEARCH_TIMEOUT=8 with seek_synced_i=0 → RST_SEEK after the 8th dv.
  - 260 forced lock losses → relock_cnt_o saturates at 255.
  - rst_i asserted while LOCKED → immediate reset values.

Source files
------------

// File: rtl/aurora_sync_pkg.sv
// Shared types and constants for the 64b/66b sync-header lock controller.
// Header encodings, state encoding and the header validity check.
package aurora_sync_pkg;

    typedef enum logic [1:0] {
        RST_SEEK = 2'd0,
        SEARCH   = 2'd1,
        VERIFY   = 2'd2,
        LOCKED   = 2'd3
    } sync_state_t;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;
    localparam int         OFFSET_W = 7;

    function automatic logic hdr_good(input logic [1:0] h);
        return (h == HDR_DATA) || (h == HDR_CTRL);
    endfunction

endpackage

// File: rtl/hdr_err_window.sv
// Bad-header window tracker used while locked.
// limit_hit flags the header that brings the bad count to ERR_LIMIT.
module hdr_err_window #(
    parameter int ERR_WINDOW = 64,
    parameter int ERR_LIMIT  = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic dv,
    input  logic bad,
    output logic limit_hit
);

    localparam logic [7:0] WIN_C = 8'(ERR_WINDOW);
    localparam logic [7:0] LIM_C = 8'(ERR_LIMIT);

    logic [7:0] win_q;
    logic [7:0] bad_q;
    logic [7:0] win_inc;
    logic [7:0] bad_inc;

    // Counts including the header sampled this cycle.
    always_comb begin
        win_inc = win_q + 8'd1;
        bad_inc = bad_q + {7'd0, bad};
    end

    assign limit_hit = dv & bad & (bad_inc >= LIM_C);

    // Window and bad counters; both restart at each window end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q <= '0;
            bad_q <= '0;
        end else if (clr) begin
            win_q <= '0;
            bad_q <= '0;
        end else if (dv) begin
            if (win_inc >= WIN_C) begin
                win_q <= '0;
                bad_q <= '0;
            end else begin
                win_q <= win_inc;
                bad_q <= bad_inc;
            end
        end
    end

endmodule

// File: rtl/block_sync_ctrl.sv
// Lock controller sequencing the sync-header seeker array.
// Owns the FSM, search timer, good counter, frozen offset and relock count.
module block_sync_ctrl
    import aurora_sync_pkg::*;
#(
    parameter int LOCK_CNT       = 32,
    parameter int ERR_WINDOW     = 64,
    parameter int ERR_LIMIT      = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int OFFSET_MAX     = 65
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                buffer_dv,
    input  logic                seek_synced_i,
    input  logic [OFFSET_W-1:0] seek_offset_i,
    input  logic [1:0]          hdr_i,
    output logic                seek_rst_o,
    output logic [OFFSET_W-1:0] offset_o,
    output logic                locked_o,
    output logic                block_dv_o,
    output logic [7:0]          relock_cnt_o,
    output logic [1:0]          state_o
);

    localparam logic [OFFSET_W-1:0] OFF_MAX_C = OFFSET_W'(OFFSET_MAX);
    localparam logic [15:0]         TMO_C     = 16'(SEARCH_TIMEOUT);
    localparam logic [7:0]          LOCK_C    = 8'(LOCK_CNT);

    sync_state_t state_q, state_d;
    logic        rst_cnt_q, rst_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  good_q, good_d;
    logic        latch;
    logic        lost;
    logic        hdr_ok;
    logic        limit_hit;

    assign hdr_ok = hdr_good(hdr_i);

    hdr_err_window #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_LIMIT  (ERR_LIMIT)
    ) u_win (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr       (state_q != LOCKED),
        .dv        (buffer_dv),
        .bad       (~hdr_ok),
        .limit_hit (limit_hit)
    );

    // Next-state and counter updates.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        timer_d   = timer_q;
        good_d    = good_q;
        latch     = 1'b0;
        lost      = 1'b0;
        unique case (state_q)
            RST_SEEK: begin
                timer_d   = '0;
                good_d    = '0;
                rst_cnt_d = 1'b1;
                if (rst_cnt_q) begin
                    rst_cnt_d = 1'b0;
                    state_d   = SEARCH;
                end
            end
            SEARCH: begin
                if (buffer_dv) begin
                    if (seek_synced_i && (seek_offset_i <= OFF_MAX_C)) begin
                        latch   = 1'b1;
                        state_d = VERIFY;
                    end else begin
                        timer_d = timer_q + 16'd1;
                        if (timer_d >= TMO_C) state_d = RST_SEEK;
                    end
                end
            end
            VERIFY: begin
                if (buffer_dv) begin
                    if (!hdr_ok) begin
                        state_d = RST_SEEK;
                    end else begin
                        good_d = good_q + 8'd1;
                        if (good_d >= LOCK_C) state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (limit_hit) begin
                    lost    = 1'b1;
                    state_d = RST_SEEK;
                end
            end
            default: state_d = RST_SEEK;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RST_SEEK;
            rst_cnt_q    <= 1'b0;
            timer_q      <= '0;
            good_q       <= '0;
            offset_o     <= '0;
            relock_cnt_o <= '0;
            seek_rst_o   <= 1'b1;
            locked_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            timer_q    <= timer_d;
            good_q     <= good_d;
            seek_rst_o <= (state_d == RST_SEEK);
            locked_o   <= (state_d == LOCKED);
            if (latch) offset_o <= seek_offset_i;
            if (lost && (relock_cnt_o != 8'hFF))
                relock_cnt_o <= relock_cnt_o + 8'd1;
        end
    end

    assign state_o    = state_q;
    assign block_dv_o = buffer_dv & locked_o;

endmodule
